// File: rtl/team_06_sram_arbiter.sv
// Round-robin arbiter sharing one wishbone manager between a write requester
// (audio record) and a read requester (playback/delay). One transaction is in
// flight at a time; a cycle counter aborts transactions whose manager never
// finishes.
module team_06_sram_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    // write requester
    input  logic        wr_req,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data,
    input  logic [3:0]  wr_sel,
    output logic        wr_gnt,
    output logic        wr_done,
    // read requester
    input  logic        rd_req,
    input  logic [31:0] rd_addr,
    output logic        rd_gnt,
    output logic        rd_done,
    output logic [31:0] rd_data,
    // wishbone manager side
    output logic [31:0] mgr_adr,
    output logic [31:0] mgr_dat_o,
    output logic [3:0]  mgr_sel,
    output logic        mgr_write,
    output logic        mgr_read,
    input  logic [31:0] mgr_dat_i,
    input  logic        mgr_busy,
    // status
    output logic        timeout_err
);

    // Counter only ever reaches TIMEOUT, so size it to hold exactly that.
    localparam int unsigned CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_CNT = CW'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        COMPLETE
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          is_wr_q, is_wr_d;      // current winner: 1 = write
    logic          last_wr_q, last_wr_d;  // last served: 1 = write
    logic [31:0]   adr_q, adr_d;
    logic [31:0]   dat_q, dat_d;
    logic [3:0]    sel_q, sel_d;
    logic [31:0]   rd_data_q, rd_data_d;
    logic          terr_q, terr_d;
    logic          pick_wr;
    logic          abort;

    // State and datapath registers; synchronous reset abandons any transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            is_wr_q   <= 1'b0;
            last_wr_q <= 1'b0;   // read counts as last served: write wins first tie
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            rd_data_q <= '0;
            terr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_wr_q   <= is_wr_d;
            last_wr_q <= last_wr_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            sel_q     <= sel_d;
            rd_data_q <= rd_data_d;
            terr_q    <= terr_d;
        end
    end

    // Next-state logic: arbitration, manager handshake tracking and timeout.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_wr_d   = is_wr_q;
        last_wr_d = last_wr_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        sel_d     = sel_q;
        rd_data_d = rd_data_q;
        terr_d    = terr_q;
        pick_wr   = 1'b0;
        abort     = 1'b0;

        case (state_q)
            IDLE: begin
                if (wr_req || rd_req) begin
                    // Write wins when alone, or on a tie when read was served last.
                    pick_wr = wr_req && (!rd_req || !last_wr_q);
                    is_wr_d = pick_wr;
                    cnt_d   = '0;
                    state_d = ISSUE;
                    if (pick_wr) begin
                        adr_d = wr_addr;
                        dat_d = wr_data;
                        sel_d = wr_sel;
                    end else begin
                        adr_d = rd_addr;
                        dat_d = '0;
                        sel_d = 4'hF;
                    end
                end
            end
            ISSUE: begin
                cnt_d   = cnt_q + CW'(1);
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == TO_CNT) begin
                    abort = 1'b1;
                end else if (mgr_busy) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                cnt_d = cnt_q + CW'(1);
                // A finish on the deadline cycle still counts as a real finish.
                if (!mgr_busy) begin
                    state_d = COMPLETE;
                    if (!is_wr_q) begin
                        rd_data_d = mgr_dat_i;
                    end
                end else if (cnt_q == TO_CNT) begin
                    abort = 1'b1;
                end
            end
            COMPLETE: begin
                last_wr_d = is_wr_q;
                cnt_d     = '0;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort) begin
            state_d = COMPLETE;
            terr_d  = 1'b1;
            if (!is_wr_q) begin
                rd_data_d = '0;
            end
        end
    end

    // Pulses decode straight from state; the winner bit steers them, so
    // the two requesters and the two strobes can never fire together.
    assign wr_gnt      = (state_q == ISSUE)    &&  is_wr_q;
    assign rd_gnt      = (state_q == ISSUE)    && !is_wr_q;
    assign mgr_write   = (state_q == ISSUE)    &&  is_wr_q;
    assign mgr_read    = (state_q == ISSUE)    && !is_wr_q;
    assign wr_done     = (state_q == COMPLETE) &&  is_wr_q;
    assign rd_done     = (state_q == COMPLETE) && !is_wr_q;

    assign mgr_adr     = adr_q;
    assign mgr_dat_o   = dat_q;
    assign mgr_sel     = sel_q;
    assign rd_data     = rd_data_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_team_06_sram_arbiter.sv
// Bench for team_06_sram_arbiter: directed scenarios with literal expectations
// plus a randomized phase, all checked every cycle against a timeline model.
module tb_team_06_sram_arbiter;

    localparam int TO = 8;

    logic        clk;
    logic        rst;
    logic        wr_req, rd_req;
    logic [31:0] wr_addr, wr_data, rd_addr;
    logic [3:0]  wr_sel;
    logic        wr_gnt, wr_done, rd_gnt, rd_done;
    logic [31:0] rd_data;
    logic [31:0] mgr_adr, mgr_dat_o, mgr_dat_i;
    logic [3:0]  mgr_sel;
    logic        mgr_write, mgr_read, mgr_busy;
    logic        timeout_err;

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    // manager responder configuration
    int          cfg_dly = 1;
    int          cfg_len = 1;
    bit          cfg_stuck = 0;
    logic [31:0] cfg_rdata = '0;

    team_06_sram_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_sel(wr_sel),
        .wr_gnt(wr_gnt), .wr_done(wr_done),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_done(rd_done),
        .rd_data(rd_data),
        .mgr_adr(mgr_adr), .mgr_dat_o(mgr_dat_o), .mgr_sel(mgr_sel),
        .mgr_write(mgr_write), .mgr_read(mgr_read),
        .mgr_dat_i(mgr_dat_i), .mgr_busy(mgr_busy),
        .timeout_err(timeout_err)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Manager: after a strobe, stay idle cfg_dly cycles (0 = busy already in
    // the strobe cycle), then hold busy for cfg_len cycles.
    initial begin : manager
        int dly, len;
        dly = 0; len = 0;
        mgr_busy = 0; mgr_dat_i = '0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                dly = 0; len = 0;
            end else if (mgr_write || mgr_read) begin
                dly = cfg_dly; len = cfg_len; mgr_dat_i = cfg_rdata;
            end
            if (dly > 0) begin
                mgr_busy = 0; dly--;
            end else if (len > 0) begin
                mgr_busy = 1; len--;
            end else begin
                mgr_busy = 0;
            end
            if (cfg_stuck) mgr_busy = 1;
        end
    end

    // Timeline model: each transaction is described by its issue cycle, the
    // cycle busy was first seen after issue, and its finish cycle.
    int          cyc = 0;
    bit          m_active = 0, m_seen = 0, m_wr = 0, m_last_wr = 0, m_terr = 0;
    int          m_issue = -1, m_done = -1, m_free = 0;
    logic [31:0] m_adr = '0, m_dat = '0, m_rdd = '0;
    logic [3:0]  m_sel = '0;

    // Model advance at each rising edge using the inputs of the ending cycle.
    always @(posedge clk) begin
        int el;
        bit fin, ab;
        if (rst) begin
            m_active = 0; m_issue = -1; m_done = -1; m_free = cyc + 1;
            m_last_wr = 0; m_adr = '0; m_dat = '0; m_sel = '0;
            m_rdd = '0; m_terr = 0;
        end else if (!m_active) begin
            if (cyc >= m_free && (wr_req || rd_req)) begin
                m_wr     = wr_req && (!rd_req || !m_last_wr);
                m_adr    = m_wr ? wr_addr : rd_addr;
                m_dat    = m_wr ? wr_data : 32'h0;
                m_sel    = m_wr ? wr_sel  : 4'hF;
                m_issue  = cyc + 1;
                m_active = 1;
                m_seen   = 0;
            end
        end else if (cyc > m_issue) begin
            el = cyc - m_issue; fin = 0; ab = 0;
            if (!m_seen) begin
                if (el == TO) begin fin = 1; ab = 1; end
                else if (mgr_busy) m_seen = 1;
            end else begin
                if (!mgr_busy) fin = 1;
                else if (el == TO) begin fin = 1; ab = 1; end
            end
            if (fin) begin
                m_active  = 0;
                m_done    = cyc + 1;
                m_free    = cyc + 2;
                m_last_wr = m_wr;
                if (ab) m_terr = 1;
                if (!m_wr) m_rdd = ab ? 32'h0 : mgr_dat_i;
            end
        end
        cyc++;
    end

    // Compare every output against the model mid-cycle.
    always @(negedge clk) begin
        bit iss, dn;
        if (chk_en) begin
            iss = (cyc == m_issue);
            dn  = (cyc == m_done);
            chk("wr_gnt",      32'(wr_gnt),      32'(iss && m_wr));
            chk("rd_gnt",      32'(rd_gnt),      32'(iss && !m_wr));
            chk("mgr_write",   32'(mgr_write),   32'(iss && m_wr));
            chk("mgr_read",    32'(mgr_read),    32'(iss && !m_wr));
            chk("wr_done",     32'(wr_done),     32'(dn && m_wr));
            chk("rd_done",     32'(rd_done),     32'(dn && !m_wr));
            chk("mgr_adr",     mgr_adr,          m_adr);
            chk("mgr_dat_o",   mgr_dat_o,        m_dat);
            chk("mgr_sel",     32'(mgr_sel),     32'(m_sel));
            chk("rd_data",     rd_data,          m_rdd);
            chk("timeout_err", 32'(timeout_err), 32'(m_terr));
        end
    end

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic do_reset();
        rst = 1; tick(); rst = 0;
    endtask

    // Wait for the selected done pulse; off = cycles after the grant cycle, -1 on expiry.
    task automatic wait_done(input bit is_wr, output int off);
        off = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (is_wr ? wr_done : rd_done) begin
                off = i;
                break;
            end
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " gnt/done/strobe"}, 32'({wr_gnt, rd_gnt, wr_done, rd_done, mgr_write, mgr_read}), 32'h0);
        chk({tag, " mgr_adr"},   mgr_adr,   32'h0);
        chk({tag, " mgr_dat_o"}, mgr_dat_o, 32'h0);
        chk({tag, " mgr_sel"},   32'(mgr_sel), 32'h0);
        chk({tag, " rd_data"},   rd_data,   32'h0);
        chk({tag, " timeout_err"}, 32'(timeout_err), 32'h0);
    endtask

    initial begin : main
        int off, n, k;
        logic [3:0] order;
        rst = 1;
        wr_req = 0; rd_req = 0; wr_addr = '0; wr_data = '0; wr_sel = '0; rd_addr = '0;
        tick(); tick();
        chk_en = 1;
        chk_all_zero("reset");
        rst = 0;
        tick();

        // single write, requester drops req right after grant
        wr_req = 1; wr_addr = 32'h10; wr_data = 32'hA5A5_0001; wr_sel = 4'hF;
        cfg_dly = 1; cfg_len = 3;
        tick();
        chk("write gnt",    32'(wr_gnt),    32'h1);
        chk("write strobe", 32'(mgr_write), 32'h1);
        chk("write adr",    mgr_adr,        32'h10);
        chk("write dat",    mgr_dat_o,      32'hA5A5_0001);
        wr_req = 0;
        wait_done(1, off);
        chk("write done offset", 32'(off), 32'd5);
        n = 0;
        for (int i = 0; i < 10; i++) begin tick(); if (wr_done) n++; end
        chk("write extra done", 32'(n), 32'd0);

        // single read, busy already high in the strobe cycle
        rd_req = 1; rd_addr = 32'h20; cfg_rdata = 32'h1234_5678; cfg_dly = 0; cfg_len = 2;
        tick();
        chk("read gnt",    32'(rd_gnt),    32'h1);
        chk("read strobe", 32'(mgr_read),  32'h1);
        chk("read adr",    mgr_adr,        32'h20);
        chk("read sel",    32'(mgr_sel),   32'hF);
        chk("read dat_o",  mgr_dat_o,      32'h0);
        rd_req = 0;
        wait_done(0, off);
        chk("read done offset", 32'(off), 32'd3);
        chk("read data",        rd_data,  32'h1234_5678);
        repeat (3) tick();
        chk("read data held",   rd_data,  32'h1234_5678);

        // contention after reset: W,R,W,R
        do_reset();
        wr_req = 1; rd_req = 1; cfg_dly = 1; cfg_len = 1;
        wr_addr = 32'h100; rd_addr = 32'h200;
        order = '0; k = 0;
        for (int i = 0; i < 100 && k < 4; i++) begin
            tick();
            if (wr_gnt) begin order[3-k] = 1'b1; k++; end
            else if (rd_gnt) k++;
        end
        chk("contention grants", 32'(k),     32'd4);
        chk("contention order",  32'(order), 32'hA);
        wr_req = 0; rd_req = 0;
        repeat (10) tick();

        // good read, then a read that times out with busy stuck
        do_reset();
        rd_req = 1; rd_addr = 32'h30; cfg_rdata = 32'hDEAD_BEEF; cfg_dly = 1; cfg_len = 1;
        tick(); rd_req = 0;
        wait_done(0, off);
        chk("pre-timeout data", rd_data, 32'hDEAD_BEEF);
        tick();
        rd_req = 1; rd_addr = 32'h40; cfg_stuck = 1;
        tick();
        chk("timeout gnt", 32'(rd_gnt), 32'h1);
        rd_req = 0;
        wait_done(0, off);
        chk("timeout done offset", 32'(off), 32'd9);
        chk("timeout data",        rd_data,  32'h0);
        chk("timeout flag",        32'(timeout_err), 32'h1);
        cfg_stuck = 0;
        repeat (5) tick();
        chk("timeout flag sticky", 32'(timeout_err), 32'h1);

        // reset while waiting for busy to fall
        rd_req = 1; rd_addr = 32'h80; cfg_rdata = 32'hCAFE_F00D; cfg_dly = 1; cfg_len = 10;
        tick();
        chk("midreset gnt", 32'(rd_gnt), 32'h1);
        rd_req = 0;
        repeat (3) tick();
        rst = 1; tick();
        chk_all_zero("midreset");
        rst = 0;
        n = 0;
        for (int i = 0; i < 15; i++) begin tick(); if (rd_done) n++; end
        chk("midreset no done", 32'(n), 32'd0);
        rd_req = 1; rd_addr = 32'h84; cfg_rdata = 32'h0000_55AA; cfg_dly = 1; cfg_len = 2;
        tick();
        chk("post-reset gnt", 32'(rd_gnt), 32'h1);
        rd_req = 0;
        wait_done(0, off);
        chk("post-reset done offset", 32'(off), 32'd4);
        chk("post-reset data",        rd_data,  32'h0000_55AA);
        tick();

        // randomized traffic, checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(399) == 0);
            wr_req    = ($urandom_range(99) < 40);
            rd_req    = ($urandom_range(99) < 40);
            wr_addr   = $urandom;
            wr_data   = $urandom;
            wr_sel    = 4'($urandom);
            rd_addr   = $urandom;
            cfg_dly   = $urandom_range(2);
            cfg_len   = ($urandom_range(9) == 0) ? 0 : 1 + $urandom_range(3);
            cfg_rdata = $urandom;
            tick();
        end
        rst = 0; wr_req = 0; rd_req = 0;
        repeat (20) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
